// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Brief    : Arbitrates two valid/ready requesters onto one combinational alu
//            and holds each result until its owner accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int DW       = 32,
    parameter int OPW      = 4,
    parameter int ARB_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_c,
    output logic [3:0]     rsp0_flags,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_c,
    output logic [3:0]     rsp1_flags,

    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_c,
    input  logic [3:0]     alu_flags,

    output logic           ovf_sticky,
    input  logic           ovf_clr,
    output logic           last_grant
);

    localparam logic [OPW-1:0] c_ALU_NOP   = OPW'(0);
    localparam logic [OPW-1:0] c_ALU_ADD   = OPW'(1);
    localparam logic [OPW-1:0] c_ALU_SUB   = OPW'(2);
    localparam logic [OPW-1:0] c_ALU_AND   = OPW'(3);
    localparam logic [OPW-1:0] c_ALU_OR    = OPW'(4);
    localparam logic [OPW-1:0] c_ALU_SLT   = OPW'(5);
    localparam logic [OPW-1:0] c_ALU_SLTU  = OPW'(6);
    localparam logic [OPW-1:0] c_ALU_ADDU  = OPW'(7);
    localparam logic [OPW-1:0] c_ALU_SUBU  = OPW'(8);
    localparam logic [OPW-1:0] c_ALU_XOR   = OPW'(9);
    localparam logic [OPW-1:0] c_ALU_NOR   = OPW'(10);
    localparam logic [OPW-1:0] c_ALU_LUI   = OPW'(11);
    localparam logic [OPW-1:0] c_ALU_SPADD = OPW'(15);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_owner;
    logic            r_last_grant;
    logic [OPW-1:0]  r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic            r_rsp0_valid;
    logic            r_rsp1_valid;
    logic [DW-1:0]   r_rsp0_c;
    logic [DW-1:0]   r_rsp1_c;
    logic [3:0]      r_rsp0_flags;
    logic [3:0]      r_rsp1_flags;
    logic            r_ovf;

    logic            w_any_req;
    logic            w_grant;
    logic            w_accept;
    logic            w_rsp_done;
    logic [3:0]      w_flags_cap;

    // Grant is a port index: 0 or 1. Ties go by mode; a lone requester always wins.
    always_comb begin
        w_any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = (ARB_MODE == 1) ? 1'b0 : ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_op      = c_ALU_NOP;
        alu_a       = '0;
        alu_b       = '0;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_accept    = 1'b1;
                    req0_ready  = ~w_grant;
                    req1_ready  = w_grant;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op      = r_op;
                alu_a       = r_a;
                alu_b       = r_b;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_done = r_owner ? rsp1_ready : rsp0_ready;
                if (w_rsp_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The alu leaves flags stale for compare/no-op codes, so those are zeroed.
    always_comb begin
        case (r_op)
            c_ALU_ADD, c_ALU_SUB, c_ALU_ADDU, c_ALU_SUBU, c_ALU_AND, c_ALU_OR,
            c_ALU_XOR, c_ALU_NOR, c_ALU_LUI, c_ALU_SPADD: w_flags_cap = alu_flags;
            default:                                       w_flags_cap = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_c     <= '0;
            r_rsp1_c     <= '0;
            r_rsp0_flags <= 4'b0000;
            r_rsp1_flags <= 4'b0000;
            r_ovf        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_op         <= w_grant ? req1_op : req0_op;
                r_a          <= w_grant ? req1_a  : req0_a;
                r_b          <= w_grant ? req1_b  : req0_b;
            end
            if (r_state == ST_EXEC) begin
                if (r_owner) begin
                    r_rsp1_c     <= alu_c;
                    r_rsp1_flags <= w_flags_cap;
                    r_rsp1_valid <= 1'b1;
                end else begin
                    r_rsp0_c     <= alu_c;
                    r_rsp0_flags <= w_flags_cap;
                    r_rsp0_valid <= 1'b1;
                end
            end
            if (w_rsp_done) begin
                if (r_owner) begin
                    r_rsp1_valid <= 1'b0;
                end else begin
                    r_rsp0_valid <= 1'b0;
                end
            end
            // A capture that sets the sticky bit outranks a simultaneous clear.
            if ((r_state == ST_EXEC) && w_flags_cap[0]) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_c     = r_rsp0_c;
    assign rsp1_c     = r_rsp1_c;
    assign rsp0_flags = r_rsp0_flags;
    assign rsp1_flags = r_rsp1_flags;
    assign ovf_sticky = r_ovf;
    assign last_grant = r_last_grant;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Brief    : Scoreboard bench for alu_share_arb with a behavioural alu model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

    localparam logic [3:0] c_ALU_NOP   = 4'd0;
    localparam logic [3:0] c_ALU_ADD   = 4'd1;
    localparam logic [3:0] c_ALU_SUB   = 4'd2;
    localparam logic [3:0] c_ALU_AND   = 4'd3;
    localparam logic [3:0] c_ALU_OR    = 4'd4;
    localparam logic [3:0] c_ALU_SLT   = 4'd5;
    localparam logic [3:0] c_ALU_SLTU  = 4'd6;
    localparam logic [3:0] c_ALU_ADDU  = 4'd7;
    localparam logic [3:0] c_ALU_SUBU  = 4'd8;
    localparam logic [3:0] c_ALU_XOR   = 4'd9;
    localparam logic [3:0] c_ALU_NOR   = 4'd10;
    localparam logic [3:0] c_ALU_LUI   = 4'd11;
    localparam logic [3:0] c_ALU_UNDEF = 4'd12;
    localparam logic [3:0] c_ALU_SPADD = 4'd15;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [3:0]  f;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp0_valid, rsp0_ready = 1, rsp1_valid, rsp1_ready = 1;
    logic [31:0] rsp0_c, rsp1_c, alu_a, alu_b, alu_c;
    logic [3:0]  rsp0_flags, rsp1_flags, alu_op, alu_flags;
    logic        ovf_sticky, ovf_clr = 0, last_grant;

    logic        fp_req0_valid = 0, fp_req0_ready, fp_req1_valid = 0, fp_req1_ready;
    logic        fp_rsp0_valid, fp_rsp1_valid, fp_ovf_sticky, fp_last_grant;
    logic [31:0] fp_rsp0_c, fp_rsp1_c, fp_alu_a, fp_alu_b, fp_alu_c;
    logic [3:0]  fp_rsp0_flags, fp_rsp1_flags, fp_alu_op, fp_alu_flags;

    int   n_tests = 0;
    int   n_fail  = 0;
    req_t rq0[$], rq1[$], sb0[$], sb1[$];
    bit   grant_log[$];

    // Stand-in alu: returns {flags, c}; compare/no-op codes leave junk flags.
    function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] c;
        logic        cy, v;
        logic [3:0]  stale;
        s = '0; c = '0; cy = 1'b0; v = 1'b0; stale = 4'b0000;
        case (op)
            c_ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b}; cy = s[32];
                v = (a[31] == b[31]) && (s[31] != a[31]);
                c = v ? 32'h0 : s[31:0];
            end
            c_ALU_SPADD: begin
                s = {1'b0, a} + {1'b0, b}; cy = s[32]; c = s[31:0];
                v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            c_ALU_ADDU: begin s = {1'b0, a} + {1'b0, b}; cy = s[32]; c = s[31:0]; end
            c_ALU_SUB: begin
                c = a - b; cy = (a < b);
                v = (a[31] != b[31]) && (c[31] != a[31]);
            end
            c_ALU_SUBU: begin c = a - b; cy = (a < b); end
            c_ALU_AND:  c = a & b;
            c_ALU_OR:   c = a | b;
            c_ALU_XOR:  c = a ^ b;
            c_ALU_NOR:  c = ~(a | b);
            c_ALU_LUI:  c = b << 16;
            c_ALU_SLT:  begin c = {31'b0, $signed(a) < $signed(b)}; stale = 4'b0110; end
            c_ALU_SLTU: begin c = {31'b0, a < b}; stale = 4'b0110; end
            c_ALU_NOP:  begin c = 32'h0; stale = 4'b1010; end
            default:    begin c = 32'hDEAD_BEEF; stale = 4'b1111; end
        endcase
        if (stale != 4'b0000) return {stale, c};
        return {(c == 32'h0), cy, c[31], v, c};
    endfunction

    assign {alu_flags, alu_c}       = alu_model(alu_op, alu_a, alu_b);
    assign {fp_alu_flags, fp_alu_c} = alu_model(fp_alu_op, fp_alu_a, fp_alu_b);

    alu_share_arb #(.DW(32), .OPW(4), .ARB_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_flags(rsp1_flags),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_flags(alu_flags),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .last_grant(last_grant)
    );

    alu_share_arb #(.DW(32), .OPW(4), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_op(c_ALU_ADD), .req0_a(32'd1), .req0_b(32'd1),
        .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_op(c_ALU_ADD), .req1_a(32'd2), .req1_b(32'd2),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(1'b1), .rsp0_c(fp_rsp0_c), .rsp0_flags(fp_rsp0_flags),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(1'b1), .rsp1_c(fp_rsp1_c), .rsp1_flags(fp_rsp1_flags),
        .alu_op(fp_alu_op), .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_c(fp_alu_c), .alu_flags(fp_alu_flags),
        .ovf_sticky(fp_ovf_sticky), .ovf_clr(1'b0), .last_grant(fp_last_grant)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [3:0] f);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.c = c; r.f = f;
        return r;
    endfunction

    // Request driver: handshakes seen at negedge, next request presented after posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (req0_valid && req0_ready && rq0.size() > 0) begin
                sb0.push_back(rq0.pop_front()); grant_log.push_back(1'b0);
            end
            if (req1_valid && req1_ready && rq1.size() > 0) begin
                sb1.push_back(rq1.pop_front()); grant_log.push_back(1'b1);
            end
            @(posedge clk); #1;
            req0_valid = (rq0.size() > 0);
            if (rq0.size() > 0) begin req0_op = rq0[0].op; req0_a = rq0[0].a; req0_b = rq0[0].b; end
            req1_valid = (rq1.size() > 0);
            if (rq1.size() > 0) begin req1_op = rq1[0].op; req1_a = rq1[0].a; req1_b = rq1[0].b; end
        end
    end

    // Response monitor: every cycle a response is shown it must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp0_valid) begin
                if (sb0.size() == 0) check("rsp0_unexpected", 1, 0);
                else begin
                    check("rsp0_c", rsp0_c, sb0[0].c);
                    check("rsp0_flags", rsp0_flags, sb0[0].f);
                    if (rsp0_ready) void'(sb0.pop_front());
                end
            end
            if (rsp1_valid) begin
                if (sb1.size() == 0) check("rsp1_unexpected", 1, 0);
                else begin
                    check("rsp1_c", rsp1_c, sb1[0].c);
                    check("rsp1_flags", rsp1_flags, sb1[0].f);
                    if (rsp1_ready) void'(sb1.pop_front());
                end
            end
        end
    end

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((rq0.size() + rq1.size() + sb0.size() + sb1.size() > 0) && i < 300) begin
            @(negedge clk); i++;
        end
        check({"drain_", name}, (i < 300), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_g;
        int i, n0, n1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp_c", {rsp0_c, rsp1_c}, 0);
        check("rst_rsp_flags", {rsp0_flags, rsp1_flags}, 0);
        check("rst_ovf_sticky", ovf_sticky, 0);
        check("rst_last_grant", last_grant, 1);
        check("rst_alu_idle", {alu_op, alu_a}, 0);
        check("rst_req_ready", {req0_ready, req1_ready}, 0);

        // single op and latency
        @(posedge clk); #1;
        rq0.push_back(mk(c_ALU_ADD, 32'd5, 32'd7, 32'd12, 4'b0000));
        i = 0;
        do begin @(negedge clk); i++; end while (!(req0_valid && req0_ready) && i < 20);
        check("t1_req0_ready", req0_valid && req0_ready, 1);
        @(negedge clk);
        check("t1_exec_no_rsp", rsp0_valid, 0);
        check("t1_alu_drive", {alu_op, alu_a, alu_b}, {c_ALU_ADD, 32'd5, 32'd7});
        @(negedge clk);
        check("t1_rsp_latency", rsp0_valid, 1);
        drain("t1");
        check("t1_last_grant", last_grant, 0);

        rq1.push_back(mk(c_ALU_AND, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 4'b0000));
        drain("port1");

        // round-robin contention, both ports back to back
        grant_log.delete();
        rq0.push_back(mk(c_ALU_ADDU, 32'hFFFFFFFF, 32'd2, 32'd1, 4'b0100));
        rq0.push_back(mk(c_ALU_OR, 32'd0, 32'd0, 32'd0, 4'b1000));
        rq1.push_back(mk(c_ALU_SUBU, 32'd1, 32'd2, 32'hFFFFFFFF, 4'b0110));
        rq1.push_back(mk(c_ALU_NOR, 32'd0, 32'd0, 32'hFFFFFFFF, 4'b0010));
        drain("rr");
        check("rr_grant_count", grant_log.size(), 4);
        exp_g = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            if (k < grant_log.size()) check($sformatf("rr_grant_%0d", k), grant_log[k], exp_g[k]);
        end
        check("rr_last_grant", last_grant, 1);

        // backpressure on port 1 while port 0 waits
        rsp1_ready = 1'b0;
        rq1.push_back(mk(c_ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000));
        i = 0;
        do begin @(negedge clk); i++; end while (!rsp1_valid && i < 20);
        check("bp_rsp1_valid", rsp1_valid, 1);
        rq0.push_back(mk(c_ALU_LUI, 32'd0, 32'h00001234, 32'h12340000, 4'b0000));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_req0_blocked", req0_ready, 0);
            check("bp_rsp1_held", {rsp1_valid, rsp1_c}, {1'b1, 32'h0FF00FF0});
        end
        @(posedge clk); #1 rsp1_ready = 1'b1;
        drain("bp");
        check("bp_last_grant", last_grant, 0);

        // overflow capture and sticky behaviour
        rq0.push_back(mk(c_ALU_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 4'b1001));
        drain("ovf1");
        check("ovf_set", ovf_sticky, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        check("ovf_clear", ovf_sticky, 0);
        rq0.push_back(mk(c_ALU_ADD, 32'h80000000, 32'h80000000, 32'd0, 4'b1101));
        i = 0;
        do begin @(negedge clk); i++; end while (alu_op != c_ALU_ADD && i < 20);
        ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        check("ovf_set_beats_clr", ovf_sticky, 1);
        drain("ovf2");

        // flag masking
        rq0.push_back(mk(c_ALU_SUB, 32'd3, 32'd3, 32'd0, 4'b1000));
        rq0.push_back(mk(c_ALU_SLT, 32'hFFFFFFFF, 32'd0, 32'd1, 4'b0000));
        rq0.push_back(mk(c_ALU_UNDEF, 32'd1, 32'd2, 32'hDEADBEEF, 4'b0000));
        rq0.push_back(mk(c_ALU_SPADD, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1100));
        rq0.push_back(mk(c_ALU_SLTU, 32'd1, 32'd2, 32'd1, 4'b0000));
        drain("mask");
        check("nonowner_rsp1_kept", {rsp1_valid, rsp1_c}, {1'b0, 32'h0FF00FF0});

        // reset while in EXEC
        rq0.push_back(mk(c_ALU_ADD, 32'd1, 32'd1, 32'd2, 4'b0000));
        i = 0;
        do begin @(negedge clk); i++; end while (alu_op != c_ALU_ADD && i < 20);
        rst = 1'b1; #1;
        sb0.delete();
        check("rst_exec_state", {rsp0_valid, rsp1_valid, last_grant, ovf_sticky, alu_op}, {4'b0010, c_ALU_NOP});
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin @(negedge clk); check("rst_exec_no_rsp", rsp0_valid, 0); end

        // reset while in RESP
        rsp0_ready = 1'b0;
        rq0.push_back(mk(c_ALU_ADD, 32'd2, 32'd2, 32'd4, 4'b0000));
        i = 0;
        do begin @(negedge clk); i++; end while (!rsp0_valid && i < 20);
        check("rst_resp_reached", rsp0_valid, 1);
        rst = 1'b1; #1;
        sb0.delete();
        check("rst_resp_state", {rsp0_valid, rsp0_c, last_grant}, {1'b0, 32'd0, 1'b1});
        @(posedge clk); #1 rst = 1'b0; rsp0_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin @(negedge clk); check("rst_resp_no_rsp", rsp0_valid, 0); end

        // after reset, a tie goes to port 0 first
        @(posedge clk); #1;
        grant_log.delete();
        rq0.push_back(mk(c_ALU_ADD, 32'd1, 32'd1, 32'd2, 4'b0000));
        rq1.push_back(mk(c_ALU_ADD, 32'd2, 32'd2, 32'd4, 4'b0000));
        drain("post_rst");
        check("post_rst_grants", {grant_log.size() == 2, grant_log.size() == 2 ? grant_log[0] : 1'b1,
                                  grant_log.size() == 2 ? grant_log[1] : 1'b0}, 3'b101);

        // fixed priority instance
        fp_req0_valid = 1'b1; fp_req1_valid = 1'b1;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (fp_req0_valid && fp_req0_ready) n0++;
            if (fp_req1_valid && fp_req1_ready) n1++;
        end
        check("fp_port0_grants", n0, 4);
        check("fp_port1_starved", n1, 0);
        @(posedge clk); #1 fp_req0_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (fp_req1_valid && fp_req1_ready) n1++;
        end
        check("fp_port1_after", n1, 1);
        @(posedge clk); #1 fp_req1_valid = 1'b0;
        check("fp_last_grant", fp_last_grant, 1);
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
